fpsqrt_req_arbiter: RTL
=======================

# fpsqrt_req_arbiter

Front-end controller that shares one `fpsqrt_vector_r16` unit among `NUM_REQ` requesters. It arbitrates round-robin, registers the winning request and issues it over the unit's start handshake. It then captures the unit's result and returns it to the owning requester over a per-requester response handshake. One operation is in flight at a time, and illegal formats are rejected without touching the unit.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 2..4.
- `ID_W`, default `$clog2(NUM_REQ)`: owner/pointer width. Derived; never override.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush_i`  in  1  global synchronous abort.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester request accept.
- `req_op_i`  in  NUM_REQ×64  operand.
- `req_fp_format_i`  in  NUM_REQ×2  format: 00 fp16, 01 fp32, 10 fp64, 11 illegal.
- `req_rm_i`  in  NUM_REQ×3  rounding mode (RNE 000 … RMM 100).
- `req_vector_mode_i`  in  NUM_REQ  vector mode.
- `resp_valid_o`  out  NUM_REQ  response valid, one-hot or zero.
- `resp_ready_i`  in  NUM_REQ  response accept.
- `resp_res_o`  out  64  result, shared by all requesters.
- `resp_fflags_o`  out  5  flags {NV,DZ,OF,UF,NX}, shared by all requesters.
- `sqrt_start_valid_o` / `sqrt_start_ready_i`  out/in  1  unit start handshake.
- `sqrt_op_o`  out  64  operand to unit.
- `sqrt_fp_format_o`  out  2  format to unit.
- `sqrt_rm_o`  out  3  rounding mode to unit.
- `sqrt_vector_mode_o`  out  1  vector mode to unit.
- `sqrt_flush_o`  out  1  flush to unit.
- `sqrt_finish_valid_i` / `sqrt_finish_ready_o`  in/out  1  unit finish handshake.
- `sqrt_res_i`  in  64  result from unit.
- `sqrt_fflags_i`  in  5  flags from unit.
- `op_count_o`  out  32  count of completed responses.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant goes to the first requester with `req_valid_i` set, searching from `rr_ptr` upward with wrap.
  - `req_ready_o[g]` = 1 for the granted requester only.
  - On accept, latch op, format, rm, vector and `owner` = g.
  - Format 11: load `res_q` = 0 and `fflags_q` = 5'b10000, then go to RESP. Otherwise go to ISSUE.
- **ISSUE**: `sqrt_start_valid_o` = 1 with the latched payload. On `sqrt_start_ready_i`, go to WAIT.
- **WAIT**: `sqrt_finish_ready_o` = 1. On `sqrt_finish_valid_i`, capture `res_q` and `fflags_q`, then go to RESP.
- **RESP**
  - `resp_valid_o[owner]` = 1; `resp_res_o` = `res_q`, `resp_fflags_o` = `fflags_q`.
  - On `resp_ready_i[owner]`: increment `op_count_o`, set `rr_ptr` = owner+1 mod NUM_REQ, go to IDLE.
- **Handshake rules**
  - Payload is stable while valid is high. Valid never drops without a handshake, except on `flush_i`.
  - `resp_ready_i` of non-owners is ignored.
- **Flush**
  - `sqrt_flush_o` = `flush_i`, combinational.
  - While `flush_i` = 1, all `req_ready_o`, `resp_valid_o`, `sqrt_start_valid_o` and `sqrt_finish_ready_o` are forced to 0. Any handshake coincident with flush does not occur.
  - Next state is IDLE. The in-flight response is dropped; `rr_ptr` and `op_count_o` are unchanged.
- **Counter**: `op_count_o` wraps from 0xFFFF_FFFF to 0.
- **Pointer**: `rr_ptr` wraps past NUM_REQ-1 to 0. Requesters are never starved: at most NUM_REQ-1 other grants occur between any two grants to a requester.

## Timing
- Reset (async assert, sync-deassert handled at top): state IDLE, `rr_ptr` 0, `owner` 0, `res_q` 0, `fflags_q` 0, `op_count_o` 0.
- All handshake outputs read 0 out of reset.
- **Latency** with an immediately ready unit and requester:
  - Accept at cycle 0, `sqrt_start_valid_o` at cycle 1.
  - Response valid 1 cycle after `sqrt_finish_valid_i` handshake.
  - Back in IDLE 1 cycle after response handshake; next grant possible that cycle.
  - Minimum gap between back-to-back grants is 4 cycles plus unit latency.
- Illegal format: accept at cycle 0, `resp_valid_o` at cycle 1.
- `req_ready_o` is combinational from `req_valid_i`, `rr_ptr` and `flush_i`. All other outputs are registered or depend only on state and `flush_i`.
- A request raised during ISSUE, WAIT or RESP waits in IDLE arbitration. There is no request queue.

## Structure
- Package `fpsqrt_arb_pkg`:
  - state enum;
  - `FMT_FP16`, `FMT_FP32`, `FMT_FP64`, `FMT_ILLEGAL`;
  - `RM_*` encodings;
  - `FFLAG_NV` = 5'b10000.
- Sub-module `fpsqrt_rr_arb`: combinational round-robin grant from a request vector and pointer. Outputs a one-hot grant and grant index.

## Test plan
- **Single request, fp32.** Requester 1 sends op 0x0000_0000_4080_0000 (4.0), format 01, RNE. Expect the same payload on `sqrt_op_o` one cycle after accept. Expect `resp_valid_o` = 2'b10 with res 0x4000_0000 and fflags 0; `op_count_o` = 1.
- **Contention.** Both requesters hold valid continuously for 4 ops. Expect grant order 0,1,0,1; `op_count_o` = 4.
- **Illegal format.** Requester 0 sends format 11. Expect no `sqrt_start_valid_o`, a response at cycle 1 with res 0 and fflags 5'b10000.
- **Backpressure.** `sqrt_start_ready_i` is held low 5 cycles, then `resp_ready_i` is held low 7 cycles. Expect payload and `resp_valid_o` stable throughout and exactly one completion.
- **Flush.** Assert `flush_i` in WAIT, then in RESP coincident with `resp_ready_i`. Expect `sqrt_flush_o` = 1 and no response. Expect `op_count_o` unchanged and the next grant taken from the unchanged `rr_ptr`.
- **Reset and wrap.** Assert reset mid-WAIT: all outputs go to 0 immediately. Force `op_count_o` to 0xFFFF_FFFF and complete one op: expect `op_count_o` = 0.

Source files
------------

// File: rtl/fpsqrt_arb_pkg.sv
// ============================================================================
// fpsqrt_arb_pkg : shared types and encodings for the fpsqrt request arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package fpsqrt_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] FMT_FP16    = 2'b00;
  localparam logic [1:0] FMT_FP32    = 2'b01;
  localparam logic [1:0] FMT_FP64    = 2'b10;
  localparam logic [1:0] FMT_ILLEGAL = 2'b11;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [4:0] FFLAG_NV = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/fpsqrt_rr_arb.sv
// ============================================================================
// fpsqrt_rr_arb : combinational round-robin grant, searching upward from ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module fpsqrt_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               gnt_valid
);

  always_comb begin : p_grant
    logic [ID_W-1:0] idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Explicit modulo keeps the rotation correct for non-power-of-two counts.
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpsqrt_req_arbiter.sv
// ============================================================================
// fpsqrt_req_arbiter : shares one fpsqrt unit among NUM_REQ requesters
// Rev 1.0
// ============================================================================
`default_nettype none

module fpsqrt_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0][63:0] req_op_i,
  input  logic [NUM_REQ-1:0][1:0]  req_fp_format_i,
  input  logic [NUM_REQ-1:0][2:0]  req_rm_i,
  input  logic [NUM_REQ-1:0]       req_vector_mode_i,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  input  logic [NUM_REQ-1:0]       resp_ready_i,
  output logic [63:0]              resp_res_o,
  output logic [4:0]               resp_fflags_o,
  output logic                     sqrt_start_valid_o,
  input  logic                     sqrt_start_ready_i,
  output logic [63:0]              sqrt_op_o,
  output logic [1:0]               sqrt_fp_format_o,
  output logic [2:0]               sqrt_rm_o,
  output logic                     sqrt_vector_mode_o,
  output logic                     sqrt_flush_o,
  input  logic                     sqrt_finish_valid_i,
  output logic                     sqrt_finish_ready_o,
  input  logic [63:0]              sqrt_res_i,
  input  logic [4:0]               sqrt_fflags_i,
  output logic [31:0]              op_count_o
);

  import fpsqrt_arb_pkg::*;

  arb_state_e          state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     owner;
  logic [63:0]         op_q;
  logic [1:0]          fmt_q;
  logic [2:0]          rm_q;
  logic                vec_q;
  logic [63:0]         res_q;
  logic [4:0]          fflags_q;
  logic [31:0]         op_count_q;

  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_valid;
  logic                accept;
  logic                start_fire;
  logic                finish_fire;
  logic                resp_fire;

  fpsqrt_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arb (
    .req       (req_valid_i),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Flush masks every handshake output so no transfer can coincide with it.
  assign req_ready_o         = (state == ST_IDLE && !flush_i) ? gnt : '0;
  assign sqrt_start_valid_o  = (state == ST_ISSUE) && !flush_i;
  assign sqrt_finish_ready_o = (state == ST_WAIT)  && !flush_i;
  assign resp_valid_o        = (state == ST_RESP && !flush_i) ? (NUM_REQ'(1) << owner) : '0;
  assign sqrt_flush_o        = flush_i;

  assign sqrt_op_o           = op_q;
  assign sqrt_fp_format_o    = fmt_q;
  assign sqrt_rm_o           = rm_q;
  assign sqrt_vector_mode_o  = vec_q;
  assign resp_res_o          = res_q;
  assign resp_fflags_o       = fflags_q;
  assign op_count_o          = op_count_q;

  assign accept      = gnt_valid && (state == ST_IDLE) && !flush_i;
  assign start_fire  = sqrt_start_valid_o & sqrt_start_ready_i;
  assign finish_fire = sqrt_finish_ready_o & sqrt_finish_valid_i;
  assign resp_fire   = resp_valid_o[owner] & resp_ready_i[owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      op_q       <= '0;
      fmt_q      <= '0;
      rm_q       <= '0;
      vec_q      <= 1'b0;
      res_q      <= '0;
      fflags_q   <= '0;
      op_count_q <= '0;
    end else if (flush_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= req_op_i[gnt_idx];
            fmt_q <= req_fp_format_i[gnt_idx];
            rm_q  <= req_rm_i[gnt_idx];
            vec_q <= req_vector_mode_i[gnt_idx];
            owner <= gnt_idx;
            // Illegal formats are answered locally and never reach the unit.
            if (req_fp_format_i[gnt_idx] == FMT_ILLEGAL) begin
              res_q    <= '0;
              fflags_q <= FFLAG_NV;
              state    <= ST_RESP;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (start_fire) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (finish_fire) begin
            res_q    <= sqrt_res_i;
            fflags_q <= sqrt_fflags_i;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_fire) begin
            op_count_q <= op_count_q + 32'd1;
            rr_ptr     <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
